// File: rtl/change_event_monitor.sv
// Watches a bus for value changes and queues timestamped change events
// (new value, changed-bit mask, time) in a first-word-fall-through FIFO.
module change_event_monitor #(
   parameter int unsigned DATA_W = 5,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TS_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [DATA_W-1:0]        evt_data,
   output logic [DATA_W-1:0]        evt_mask,
   output logic [TS_W-1:0]          evt_time,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] mask;
      logic [TS_W-1:0]   ts;
   } evt_t;

   evt_t              mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [TS_W-1:0]   ts;
   logic [DATA_W-1:0] prev;
   logic              armed;

   logic              change_c;
   logic              pop_c;
   logic              push_c;
   logic              drop_c;
   logic [CNT_W-1:0]  count_nxt_c;
   evt_t              wr_entry_c;

   // Event detection and FIFO occupancy bookkeeping; a pop frees room for a same-edge push.
   always_comb begin
      change_c    = en && armed && (in_data != prev);
      pop_c       = (count != '0) && evt_ready;
      push_c      = change_c && ((count != FULL_CNT) || pop_c);
      drop_c      = change_c && !push_c;
      wr_entry_c  = '{data: in_data, mask: in_data ^ prev, ts: ts};
      count_nxt_c = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt_c = count + CNT_W'(1);
         2'b01:   count_nxt_c = count - CNT_W'(1);
         default: count_nxt_c = count;
      endcase
   end

   // Sampling state: timestamp, previous bus value and arm flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts    <= '0;
         prev  <= '0;
         armed <= 1'b0;
      end else if (en) begin
         ts    <= ts + TS_W'(1);
         prev  <= in_data;
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (push_c) begin
         mem[wr_ptr] <= wr_entry_c;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         evt_valid <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt_c;
         evt_valid <= (count_nxt_c != '0);
      end
   end

   // A drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop_c) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   assign evt_data = mem[rd_ptr].data;
   assign evt_mask = mem[rd_ptr].mask;
   assign evt_time = mem[rd_ptr].ts;

endmodule

// File: doc/change_event_monitor.md
CHANGE_EVENT_MONITOR -- requirements
Module: change_event_monitor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 5, giving the width of the monitored bus.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of event FIFO entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have parameter TS_W, default 16, giving the timestamp width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: sampling enable.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: the monitored bus.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: the FIFO head holds an event.
REQ-009 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-010 The block SHALL have port evt_data, output, DATA_W bits: the head event's new bus value.
REQ-011 The block SHALL have port evt_mask, output, DATA_W bits: the head event's changed-bit mask.
REQ-012 The block SHALL have port evt_time, output, TS_W bits: the head event's timestamp.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of FIFO entries held.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-015 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-016 The timestamp counter ts SHALL increment by 1 on every edge with en=1.
  - It wraps from 2^TS_W-1 to 0.
  - It holds its value when en=0.
REQ-017 On the first edge with en=1 after reset, the block SHALL capture in_data into prev, set armed=1 and generate no event.
REQ-018 On each edge with en=1 and armed=1, the block SHALL load prev from in_data.
  - An event is generated when in_data != prev.
  - Event contents: data = in_data, mask = in_data XOR prev, time = ts before the increment.
REQ-019 When en=0, prev, armed and ts SHALL hold and no event SHALL be generated; pops still proceed.
REQ-020 Events SHALL be pushed into a first-word-fall-through FIFO, so an event sampled at edge k into an empty FIFO gives evt_valid=1 immediately after edge k (latency 1 edge).
REQ-021 evt_valid SHALL equal (count != 0), and evt_data, evt_mask and evt_time SHALL present the head entry, stable while evt_valid=1 and evt_ready=0.
REQ-022 A pop SHALL occur on an edge where evt_valid=1 and evt_ready=1; evt_ready is ignored when the FIFO is empty.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged.
  - When the FIFO is full, the push succeeds and no overflow occurs.
  - When the FIFO is empty, no pop occurs and the push succeeds.
REQ-024 When an event occurs with count=DEPTH and no pop on that edge, the event SHALL be dropped.
  - overflow is set to 1.
  - FIFO contents and count are unchanged.
  - prev is still updated.
REQ-025 clr_ovf=1 SHALL clear overflow on the next edge, unless a drop occurs on that same edge, in which case overflow stays 1.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH.

Reset
REQ-027 While rst_n=0, the block SHALL hold these values:
  - evt_valid=0, evt_data=0, evt_mask=0, evt_time=0
  - count=0, overflow=0
  - ts=0, prev=0, armed=0
  - pointers=0
REQ-028 Reset asserted mid-operation SHALL discard all queued events immediately; after release, the block re-arms per REQ-017.

Verification
REQ-029 The bench SHALL cover arming and first event:
  - Stimulus: reset, en=1, in_data=5'h00 for 3 edges, then 5'h13 at edge 4, evt_ready=0.
  - Response: one event with data=13, mask=13, time=3; count=1.
REQ-030 The bench SHALL cover no change:
  - Stimulus: in_data held at 5'h0A for 10 edges after arming.
  - Response: evt_valid stays 0 and ts advances by 10.
REQ-031 The bench SHALL cover overflow:
  - Stimulus: evt_ready=0, in_data toggling 00/1F every edge for 6 changes.
  - Response: count=4, overflow=1, and the head shows the first change (mask=1F).
REQ-032 The bench SHALL cover push and pop when full:
  - Stimulus: FIFO full, a change while evt_ready=1.
  - Response: count stays 4, overflow stays 0, and the new entry is at the tail.
REQ-033 The bench SHALL cover clear versus drop:
  - Stimulus: overflow=1 with clr_ovf=1 on the same edge as a drop.
  - Response: overflow stays 1, and a clr_ovf on a following edge with no drop gives overflow=0.
REQ-034 The bench SHALL cover en gating and reset:
  - Stimulus: en=0 while in_data changes 01 to 02, then en=1.
  - Response: no event during en=0, and an event with mask=prev XOR 02 on the first en=1 edge.
  - Stimulus: rst_n pulse with count=3.
  - Response: count=0 and evt_valid=0 immediately.
